// File: rtl/time_pkg.sv
// Shared types and constants for the time-of-day set controller.
// Field limits are kept as plain integers so every wrap is an explicit compare.
package time_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_e;

    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;
    localparam int HR_W    = 5;
    localparam int FIELD_W = 6;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

    // Step a field by one, wrapping at 0 and at max_val.
    function automatic logic [FIELD_W-1:0] wrap_step(input logic [FIELD_W-1:0] val,
                                                     input logic [FIELD_W-1:0] max_val,
                                                     input logic               up);
        if (up) begin
            return (val == max_val) ? '0 : val + FIELD_W'(1);
        end
        return (val == '0) ? max_val : val - FIELD_W'(1);
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Bus between the set controller (master) and the sec/min/hr counter (slave):
// count enable, parallel load, and the live time fed back.
interface time_set_ctrl_if;
    import time_pkg::*;

    logic             cnt_en;
    logic             ld_en;
    logic [SEC_W-1:0] ld_sec;
    logic [MIN_W-1:0] ld_min;
    logic [HR_W-1:0]  ld_hr;
    logic [SEC_W-1:0] cur_sec;
    logic [MIN_W-1:0] cur_min;
    logic [HR_W-1:0]  cur_hr;

    modport master (
        output cnt_en, ld_en, ld_sec, ld_min, ld_hr,
        input  cur_sec, cur_min, cur_hr
    );

    modport slave (
        input  cnt_en, ld_en, ld_sec, ld_min, ld_hr,
        output cur_sec, cur_min, cur_hr
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider: tick on the last count of each period, half on the
// last count of its first half. clr restarts the period from zero.
module tick_prescaler #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick,
    output logic half
);

    localparam int W = $clog2(DIV);
    localparam logic [W-1:0] LAST      = W'(DIV - 1);
    localparam logic [W-1:0] HALF_LAST = W'(DIV / 2 - 1);

    logic [W-1:0] pre_q, pre_d;

    always_comb begin
        if (clr || pre_q == LAST) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = (pre_q == LAST);
    assign half = (pre_q == HALF_LAST);

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel set-time controller: 1 Hz count enable, hour/minute edit FSM
// with idle timeout, one-cycle commit load, and display/blink drive.
module time_set_ctrl
    import time_pkg::*;
#(
    parameter int TICK_DIV  = 100,
    parameter int TIMEOUT_S = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_mode,
    input  logic             key_inc,
    input  logic             key_dec,
    time_set_ctrl_if.master  bus,
    output logic [MIN_W-1:0] disp_min,
    output logic [HR_W-1:0]  disp_hr,
    output logic             blink_hr,
    output logic             blink_min,
    output logic [1:0]       mode
);

    localparam int IDLE_W = $clog2(TIMEOUT_S + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_S - 1);

    state_e            state_q, state_d;
    logic [HR_W-1:0]   edit_hr_q, edit_hr_d;
    logic [MIN_W-1:0]  edit_min_q, edit_min_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              phase_q, phase_d;

    logic tick, half;
    logic key_any, step_en, editing;

    // Seconds only ever load as zero; the live value is not needed here.
    logic unused_cur_sec;
    assign unused_cur_sec = ^bus.cur_sec;

    tick_prescaler #(.DIV(TICK_DIV)) u_pre (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q == COMMIT),
        .tick (tick),
        .half (half)
    );

    assign key_any = key_mode | key_inc | key_dec;
    assign step_en = key_inc ^ key_dec;
    assign editing = (state_q == SET_HR) || (state_q == SET_MIN);

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        edit_hr_d  = edit_hr_q;
        edit_min_d = edit_min_q;
        idle_d     = idle_q;
        phase_d    = phase_q ^ (tick | half);

        unique case (state_q)
            RUN: begin
                if (key_mode) begin
                    state_d    = SET_HR;
                    edit_hr_d  = bus.cur_hr;
                    edit_min_d = bus.cur_min;
                    idle_d     = '0;
                end
            end
            SET_HR, SET_MIN: begin
                if (key_mode) begin
                    state_d = (state_q == SET_HR) ? SET_MIN : COMMIT;
                end else if (step_en) begin
                    if (state_q == SET_HR) begin
                        edit_hr_d = HR_W'(wrap_step(FIELD_W'(edit_hr_q), FIELD_W'(HR_MAX), key_inc));
                    end else begin
                        edit_min_d = wrap_step(edit_min_q, FIELD_W'(MIN_MAX), key_inc);
                    end
                end
                // Any key, even a cancelling inc+dec pair, restarts the idle window.
                if (key_any) begin
                    idle_d = '0;
                end else if (tick) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d = RUN;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            COMMIT: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            edit_hr_q  <= '0;
            edit_min_q <= '0;
            idle_q     <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            edit_hr_q  <= edit_hr_d;
            edit_min_q <= edit_min_d;
            idle_q     <= idle_d;
            phase_q    <= phase_d;
        end
    end

    assign bus.cnt_en = tick && (state_q == RUN);
    assign bus.ld_en  = (state_q == COMMIT);
    assign bus.ld_sec = '0;
    assign bus.ld_min = edit_min_q;
    assign bus.ld_hr  = edit_hr_q;

    // Display is forced blank while reset is held, then tracks live time.
    assign disp_hr  = rst ? '0 : (editing ? edit_hr_q  : bus.cur_hr);
    assign disp_min = rst ? '0 : (editing ? edit_min_q : bus.cur_min);

    assign blink_hr  = (state_q == SET_HR)  && phase_q;
    assign blink_min = (state_q == SET_MIN) && phase_q;
    assign mode      = state_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl with a cycle-level behavioural model
// built from the time-setting rules (modular arithmetic, tick counting).
module tb_time_set_ctrl;
    import time_pkg::*;

    localparam int TD = 10;
    localparam int TO = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_mode, key_inc, key_dec;
    logic [5:0] disp_min;
    logic [4:0] disp_hr;
    logic       blink_hr, blink_min;
    logic [1:0] mode;

    time_set_ctrl_if bus();

    time_set_ctrl #(.TICK_DIV(TD), .TIMEOUT_S(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .key_dec   (key_dec),
        .bus       (bus),
        .disp_min  (disp_min),
        .disp_hr   (disp_hr),
        .blink_hr  (blink_hr),
        .blink_min (blink_min),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: 0 run, 1 hours, 2 minutes, 3 commit.
    int m_state, m_pre, m_phase, m_idle, m_ehr, m_emin;
    bit m_tick;

    task automatic model_reset();
        m_state = 0; m_pre = 0; m_phase = 0; m_idle = 0; m_ehr = 0; m_emin = 0; m_tick = 0;
    endtask

    task automatic model_step(input bit km, input bit ki, input bit kd);
        int ns;
        ns = m_state;
        m_tick = (m_pre == TD - 1);
        if (m_pre == TD - 1 || m_pre == TD / 2 - 1) m_phase = 1 - m_phase;
        case (m_state)
            0: if (km) begin ns = 1; m_ehr = int'(bus.cur_hr); m_emin = int'(bus.cur_min); m_idle = 0; end
            1, 2: begin
                if (km) ns = m_state + 1;
                else if (ki != kd) begin
                    if (m_state == 1) m_ehr  = ki ? (m_ehr + 1) % 24  : (m_ehr + 23) % 24;
                    else              m_emin = ki ? (m_emin + 1) % 60 : (m_emin + 59) % 60;
                end
                if (km || ki || kd) m_idle = 0;
                else if (m_tick) begin
                    m_idle++;
                    if (m_idle == TO) begin ns = 0; m_idle = 0; end
                end
            end
            default: ns = 0;
        endcase
        m_pre = (m_state == 3) ? 0 : (m_pre + 1) % TD;
        m_state = ns;
    endtask

    task automatic cycle(input bit km, input bit ki, input bit kd);
        key_mode = km; key_inc = ki; key_dec = kd;
        @(posedge clk);
        model_step(km, ki, kd);
        #1;
        key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
    endtask

    // Observed outputs; load fields only matter while a load is expected.
    function automatic logic [33:0] obs_vec(input bit show_ld);
        return {bus.cnt_en, bus.ld_en, bus.ld_sec,
                show_ld ? bus.ld_min : 6'd0, show_ld ? bus.ld_hr : 5'd0,
                disp_min, disp_hr, blink_hr, blink_min, mode};
    endfunction

    function automatic logic [33:0] obs_all();
        return {bus.cnt_en, bus.ld_en, bus.ld_sec, bus.ld_min, bus.ld_hr,
                disp_min, disp_hr, blink_hr, blink_min, mode};
    endfunction

    function automatic logic [33:0] exp_vec();
        bit ld, ed;
        ld = (m_state == 3);
        ed = (m_state == 1 || m_state == 2);
        return {1'(m_pre == TD - 1 && m_state == 0), 1'(ld), 6'd0,
                ld ? 6'(m_emin) : 6'd0, ld ? 5'(m_ehr) : 5'd0,
                ed ? 6'(m_emin) : bus.cur_min, ed ? 5'(m_ehr) : bus.cur_hr,
                1'(m_state == 1 && m_phase == 1), 1'(m_state == 2 && m_phase == 1), 2'(m_state)};
    endfunction

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        int first, second;
        logic [33:0] o;
        key_mode = 0; key_inc = 0; key_dec = 0;
        bus.cur_sec = 6'd56; bus.cur_min = 6'd34; bus.cur_hr = 5'd12;
        rst = 1'b1;
        #23;
        o = obs_all();
        total++; if (o !== 34'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", o); end
        release_reset();
        total++;
        if ({disp_hr, disp_min} !== {5'd12, 6'd34}) begin
            bad++; $display("FAIL reset_disp_follow got=%0d:%0d want=12:34", disp_hr, disp_min);
        end
        first = -1; second = -1;
        for (int i = 1; i <= 35; i++) begin
            cycle(0, 0, 0);
            o = obs_vec(m_state == 3);
            total++; if (o !== exp_vec()) begin bad++; $display("FAIL free_run c%0d got=%h want=%h", i + 1, o, exp_vec()); end
            if (bus.cnt_en === 1'b1) begin
                if (first < 0) first = i + 1;
                else if (second < 0) second = i + 1;
            end
        end
        total++; if (first !== TD)     begin bad++; $display("FAIL first_cnt_en got=%0d want=%0d", first, TD); end
        total++; if (second !== 2 * TD) begin bad++; $display("FAIL second_cnt_en got=%0d want=%0d", second, 2 * TD); end
    endtask

    task automatic test_set_sequence();
        bit km[6] = '{1, 0, 0, 1, 0, 1};
        bit ki[6] = '{0, 1, 1, 0, 0, 0};
        bit kd[6] = '{0, 0, 0, 0, 1, 0};
        int want_mode[6] = '{1, 1, 1, 2, 2, 3};
        int loads, stray, n;
        bus.cur_hr = 5'd5; bus.cur_min = 6'd30; bus.cur_sec = 6'd17;
        cycle(0, 0, 0);
        loads = 0; stray = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(km[i], ki[i], kd[i]);
            total++;
            if (mode !== 2'(want_mode[i])) begin bad++; $display("FAIL seq_mode step%0d got=%0d want=%0d", i, mode, want_mode[i]); end
            if (bus.ld_en === 1'b1) loads++;
            if (bus.cnt_en === 1'b1) stray++;
        end
        total++;
        if ({bus.ld_hr, bus.ld_min, bus.ld_sec} !== {5'd7, 6'd29, 6'd0}) begin
            bad++; $display("FAIL seq_load got=%0d:%0d:%0d want=7:29:0", bus.ld_hr, bus.ld_min, bus.ld_sec);
        end
        n = 0;
        for (int i = 0; i < 3 * TD; i++) begin
            cycle(0, 0, 0);
            n++;
            if (bus.ld_en === 1'b1) loads++;
            if (bus.cnt_en === 1'b1) break;
        end
        total++; if (n !== TD)    begin bad++; $display("FAIL seq_cnt_after_commit got=%0d want=%0d", n, TD); end
        total++; if (loads !== 1) begin bad++; $display("FAIL seq_ld_pulses got=%0d want=1", loads); end
        total++; if (stray !== 0) begin bad++; $display("FAIL seq_cnt_en_in_set got=%0d want=0", stray); end
    endtask

    task automatic test_wraps();
        bit km[8] = '{1, 0, 0, 0, 0, 1, 0, 0};
        bit ki[8] = '{0, 1, 0, 0, 1, 0, 1, 0};
        bit kd[8] = '{0, 0, 1, 1, 0, 0, 0, 1};
        int want[8] = '{23, 0, 23, 22, 23, 59, 0, 59};
        int got;
        bus.cur_hr = 5'd23; bus.cur_min = 6'd59;
        for (int i = 0; i < 8; i++) begin
            cycle(km[i], ki[i], kd[i]);
            got = (mode == 2'd2) ? int'(disp_min) : int'(disp_hr);
            total++; if (got !== want[i]) begin bad++; $display("FAIL wrap step%0d got=%0d want=%0d", i, got, want[i]); end
        end
        cycle(1, 0, 0);
        total++;
        if ({bus.ld_en, bus.ld_hr, bus.ld_min} !== {1'b1, 5'd23, 6'd59}) begin
            bad++; $display("FAIL wrap_load got=%0d %0d:%0d want=1 23:59", bus.ld_en, bus.ld_hr, bus.ld_min);
        end
        cycle(0, 0, 0);
    endtask

    task automatic test_simultaneous();
        bus.cur_hr = 5'd10; bus.cur_min = 6'd20;
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        total++;
        if ({mode, disp_hr} !== {2'd2, 5'd10}) begin bad++; $display("FAIL sim_mode_inc got=%0d/%0d want=2/10", mode, disp_hr); end
        cycle(0, 1, 1);
        total++;
        if ({mode, disp_min} !== {2'd2, 6'd20}) begin bad++; $display("FAIL sim_inc_dec got=%0d/%0d want=2/20", mode, disp_min); end
        cycle(0, 1, 0);
        cycle(1, 0, 0);
        total++;
        if ({bus.ld_en, bus.ld_hr, bus.ld_min} !== {1'b1, 5'd10, 6'd21}) begin
            bad++; $display("FAIL sim_load got=%0d %0d:%0d want=1 10:21", bus.ld_en, bus.ld_hr, bus.ld_min);
        end
        cycle(0, 0, 0);
    endtask

    task automatic test_timeout();
        int ticks, n, loads;
        bit done;
        // Plain timeout from entry.
        cycle(1, 0, 0);
        ticks = 0; n = 0; loads = 0; done = 0;
        for (int i = 0; i < 5 * TD; i++) begin
            cycle(0, 0, 0);
            n++;
            if (m_tick) ticks++;
            if (bus.ld_en === 1'b1) loads++;
            if (mode === 2'd0) begin done = 1; break; end
        end
        total++; if (!done) begin bad++; $display("FAIL timeout_bound mode=%0d want=0 within %0d", mode, 5 * TD); end
        total++; if (ticks !== TO) begin bad++; $display("FAIL timeout_ticks got=%0d want=%0d", ticks, TO); end
        total++; if (n <= 2 * TD || n > 3 * TD) begin bad++; $display("FAIL timeout_cycles got=%0d want=%0d..%0d", n, 2 * TD + 1, 3 * TD); end
        // Restarted by a key after two ticks.
        cycle(1, 0, 0);
        ticks = 0;
        for (int i = 0; i < 5 * TD && ticks < 2; i++) begin
            cycle(0, 0, 0);
            if (m_tick) ticks++;
        end
        cycle(0, 1, 0);
        ticks = 0; n = 0; done = 0;
        for (int i = 0; i < 5 * TD; i++) begin
            cycle(0, 0, 0);
            n++;
            if (m_tick) ticks++;
            if (bus.ld_en === 1'b1) loads++;
            if (mode === 2'd0) begin done = 1; break; end
        end
        total++; if (!done || ticks !== TO) begin bad++; $display("FAIL timeout_restart ticks=%0d done=%0d want=%0d/1", ticks, done, TO); end
        total++; if (n <= 2 * TD || n > 3 * TD) begin bad++; $display("FAIL timeout_restart_cycles got=%0d want=%0d..%0d", n, 2 * TD + 1, 3 * TD); end
        total++; if (loads !== 0) begin bad++; $display("FAIL timeout_no_load got=%0d want=0", loads); end
    endtask

    task automatic test_reset_mid_edit();
        int last_edge, toggles, loads;
        logic prev;
        logic [33:0] o;
        bus.cur_hr = 5'd8; bus.cur_min = 6'd45;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        prev = blink_min; last_edge = -1; toggles = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0);
            o = obs_vec(0);
            total++; if (o !== exp_vec()) begin bad++; $display("FAIL blink_model c%0d got=%h want=%h", i, o, exp_vec()); end
            if (blink_min !== prev) begin
                if (last_edge >= 0) begin
                    total++;
                    if (i - last_edge !== TD / 2) begin bad++; $display("FAIL blink_period got=%0d want=%0d", i - last_edge, TD / 2); end
                end
                last_edge = i; toggles++;
            end
            prev = blink_min;
        end
        total++; if (toggles < 3) begin bad++; $display("FAIL blink_toggles got=%0d want>=3", toggles); end
        #2 rst = 1'b1;
        #1 o = obs_all();
        total++; if (o !== 34'd0) begin bad++; $display("FAIL async_reset got=%h want=0", o); end
        @(posedge clk); #1;
        release_reset();
        total++;
        if ({mode, disp_hr, disp_min} !== {2'd0, 5'd8, 6'd45}) begin
            bad++; $display("FAIL post_reset got=%0d %0d:%0d want=0 8:45", mode, disp_hr, disp_min);
        end
        loads = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(0, 0, 0);
            if (bus.ld_en === 1'b1) loads++;
        end
        total++; if (loads !== 0) begin bad++; $display("FAIL post_reset_no_load got=%0d want=0", loads); end
    endtask

    task automatic test_random();
        int r;
        logic [33:0] o;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                bus.cur_hr  = 5'($urandom_range(0, HR_MAX));
                bus.cur_min = 6'($urandom_range(0, MIN_MAX));
                bus.cur_sec = 6'($urandom_range(0, SEC_MAX));
            end
            r = $urandom_range(0, (i < 500) ? 99 : 399);
            cycle(r < 4, r >= 4 && r < 12, r >= 8 && r < 16);
            o = obs_vec(m_state == 3);
            total++; if (o !== exp_vec()) begin bad++; $display("FAIL random c%0d got=%h want=%h", i, o, exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_set_sequence();
        test_wraps();
        test_simultaneous();
        test_timeout();
        test_reset_mid_edit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Controller that sequences and configures the sec/min/hr time-of-day counter.
- Generates the 1 Hz count enable.
- Runs a key-driven set-time state machine: edit hours, then minutes.
- Commits edited values through a one-cycle parallel load.
- Drives display-mux and blink outputs for the front panel.

Parameters:
- TICK_DIV, 100, clk cycles per second tick; must be even and >= 4.
- TIMEOUT_S, 10, seconds without a key press in a set state before the edit is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- key_mode  in  1  single-cycle pulse, already debounced: advance mode
- key_inc  in  1  single-cycle pulse: increment the edited field
- key_dec  in  1  single-cycle pulse: decrement the edited field
- cur_sec  in  6  live seconds from the counter
- cur_min  in  6  live minutes from the counter
- cur_hr  in  5  live hours from the counter
- cnt_en  out  1  one-cycle count-enable pulse to the counter
- ld_en  out  1  one-cycle parallel-load strobe
- ld_sec  out  6  load value for seconds; always 0
- ld_min  out  6  load value for minutes
- ld_hr  out  5  load value for hours
- disp_min  out  6  minutes to display
- disp_hr  out  5  hours to display
- blink_hr  out  1  hours field blank phase
- blink_min  out  1  minutes field blank phase
- mode  out  2  current state encoding

Behaviour:
Clock and reset:
- One clock, clk. Reset rst is asynchronous, active-high.
- Reset values: state RUN, prescaler 0, blink phase 0, idle counter 0, edit regs 0.
- All outputs are 0 in reset; disp_* follow cur_* as soon as rst deasserts.

Prescaler:
- pre counts 0..TICK_DIV-1 and wraps. It runs in every state.
- Tick = (pre == TICK_DIV-1).
- cnt_en = tick AND state==RUN, registered-free (combinational from registers).
- Blink phase toggles when pre == TICK_DIV/2-1 and when pre == TICK_DIV-1.

FSM states (mode encoding): RUN=0, SET_HR=1, SET_MIN=2, COMMIT=3.
- RUN, key_mode: go to SET_HR. Same edge loads edit_hr<=cur_hr, edit_min<=cur_min; idle counter <= 0.
- SET_HR:
  - key_inc: edit_hr +1, wraps 23->0.
  - key_dec: edit_hr -1, wraps 0->23.
  - key_mode: go to SET_MIN.
- SET_MIN:
  - key_inc/key_dec: same rules on edit_min, wrapping 59<->0.
  - key_mode: go to COMMIT.
- COMMIT:
  - Lasts exactly 1 cycle, then RUN.
  - ld_en=1, ld_hr=edit_hr, ld_min=edit_min, ld_sec=0, cnt_en=0.
  - pre is cleared to 0 on this edge, so the first cnt_en comes TICK_DIV cycles after RUN re-entry.
- ld_en is 0 in all other states.
- ld_min/ld_hr always show edit regs; ld_sec is tied 0.

Key priority and simultaneous events:
- key_mode beats key_inc/key_dec in the same cycle; the inc/dec is dropped.
- key_inc and key_dec together: no change, but the idle counter still clears.
- Keys have no effect in RUN except key_mode, and no effect in COMMIT.

Timeout:
- In SET_HR/SET_MIN the idle counter increments on each tick and clears on any key pulse.
- When it reaches TIMEOUT_S, go to RUN with no load and edits discarded; the counter has stayed paused throughout.

Display:
- In RUN/COMMIT, disp_* = cur_*.
- In SET_*, disp_* = edit_*.
- blink_hr = (state==SET_HR) AND phase.
- blink_min = (state==SET_MIN) AND phase.

Reset mid-edit:
- Immediate return to RUN, no ld_en, edits lost.

Arithmetic:
- Wrap is done by explicit compare against the MAX constant, never by modular width.
- Idle counter is sized $clog2(TIMEOUT_S+1).

Decomposition:
- Package time_pkg holds:
  - enum state_e {RUN, SET_HR, SET_MIN, COMMIT} as 2-bit logic.
  - Constants SEC_MAX=59, MIN_MAX=59, HR_MAX=23.
  - Width localparams SEC_W=6, MIN_W=6, HR_W=5.
- One sub-module, tick_prescaler (params DIV; ports clk, rst, clr, tick, half).
  - Reused for cnt_en and blink phase.
- FSM, edit regs and idle counter stay in time_set_ctrl.

Test Plan (TICK_DIV=10, TIMEOUT_S=3):
- Reset release, no keys: first cnt_en at cycle 10 after rst falls, then every 10 cycles; ld_en stays 0; disp_* == cur_*.
- cur=05:30. key_mode, 2x key_inc, key_mode, 1x key_dec, key_mode.
  - Expect mode 0->1->2->3->0.
  - Expect exactly one ld_en pulse with ld_hr=7, ld_min=29, ld_sec=0.
  - No cnt_en while mode!=0.
  - Next cnt_en exactly 10 cycles after COMMIT.
- Wrap checks:
  - edit_hr=23 + key_inc -> 0.
  - edit_hr=0 + key_dec -> 23.
  - edit_min=59 + key_inc -> 0.
  - edit_min=0 + key_dec -> 59.
- Simultaneous keys:
  - key_inc+key_dec in SET_MIN -> value unchanged.
  - key_mode+key_inc in SET_HR -> enters SET_MIN with edit_hr unchanged.
- Timeout: enter SET_HR, no keys for 3 ticks -> mode returns to 0 with no ld_en. A key_inc at tick 2 restarts the count, so the return comes 3 ticks after that key.
- Assert rst during SET_MIN -> all outputs 0 asynchronously, mode=0 after release, no ld_en. blink_min toggles every 5 cycles in SET_MIN before the reset.
